// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. It computes A - B one bit per clock,
// LSB first, using one full-subtractor cell and a registered borrow. A
// start/done handshake controls each operation. The result and its flags are
// held stable until the next operation completes.
//
// Parameters
//   WIDTH     operand / result width in bits (>= 2)
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high; clears all state immediately
//   start     request, sampled only while idle
//   op_a      minuend, captured on the accepting edge
//   op_b      subtrahend, captured on the accepting edge
//   busy      high while shifting and during the done cycle
//   done      one-cycle pulse; result valid from this cycle on
//   diff      A - B modulo 2^WIDTH
//   borrow    unsigned borrow (A < B as unsigned)
//   overflow  signed overflow of A - B
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  // The counter must be able to hold WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;

  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;

  // Full-subtractor cell operating on the current LSBs and the borrow flop.
  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_work_next;
  logic             w_last;

  always_comb begin
    w_a0        = r_a[0];
    w_b0        = r_b[0];
    w_d         = w_a0 ^ w_b0 ^ r_br;
    w_br_next   = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    // Each new difference bit enters at the MSB. After WIDTH shifts the
    // first (LSB) bit has reached position 0.
    w_work_next = {w_d, r_work[WIDTH-1:1]};
    w_last      = (r_cnt == LAST_SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_work     <= '0;
      r_br       <= 1'b0;
      r_cnt      <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_a_msb <= op_a[WIDTH-1];
            r_b_msb <= op_b[WIDTH-1];
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_work <= w_work_next;
          r_br   <= w_br_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            // Publish the result. The last difference bit computed is the
            // result MSB, used for the signed overflow test.
            r_diff     <= w_work_next;
            r_borrow   <= w_br_next;
            r_overflow <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end

        S_DONE: begin
          // Any start seen here is dropped. The return to idle is unconditional.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       overflow;

  int n_checks;
  int n_errors;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and watch WIDTH+8 cycles.
  // Observation n is the falling edge that follows edge E_n (E0 = accept).
  // If inject is set, extra starts with 0xFF/0x00 are presented so that they
  // are sampled at E4 (during the shifts) and at E9 (during the done cycle).
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] prev_diff,
                        input logic [7:0] e_diff, input logic e_borrow,
                        input logic e_ovf, input bit inject);
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 8'hA5;   // operands may change freely after the accepting edge
    op_b  = 8'h5A;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          chk({name, " diff"}, diff, e_diff);
          chk({name, " borrow"}, borrow, e_borrow);
          chk({name, " overflow"}, overflow, e_ovf);
        end
      end
      if (n == 4) chk({name, " diff held during shift"}, diff, prev_diff);
      if (inject) begin
        if (n == 3 || n == 8) begin
          start = 1'b1;
          op_a  = 8'hFF;
          op_b  = 8'h00;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk({name, " done cycle"}, done_at, 8);
    chk({name, " done pulses"}, done_cnt, 1);
    chk({name, " busy cycles"}, busy_cnt, 9);
    chk({name, " diff held after"}, diff, e_diff);
    $display("op %s: 0x%02h - 0x%02h -> diff=0x%02h borrow=%0d ovf=%0d", name, a, b, diff, borrow, overflow);
  endtask

  initial begin
    int busy_seen;
    int done_seen;
    n_checks = 0;
    n_errors = 0;
    start = 1'b0;
    op_a  = 8'h00;
    op_b  = 8'h00;
    reset = 1'b0;

    // Reset applied between clock edges.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset borrow", borrow, 0);
    chk("reset overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    $display("reset applied and released");

    // With start low, nothing happens.
    busy_seen = 0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    chk("idle busy", busy_seen, 0);
    chk("idle done", done_seen, 0);

    run_op("35-12", 8'h35, 8'h12, 8'h00, 8'h23, 1'b0, 1'b0, 1'b0);
    run_op("12-35", 8'h12, 8'h35, 8'h23, 8'hDD, 1'b1, 1'b0, 1'b0);
    run_op("80-01", 8'h80, 8'h01, 8'hDD, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op("ignored starts", 8'h35, 8'h12, 8'h7F, 8'h23, 1'b0, 1'b0, 1'b1);
    chk("no op after ignored starts", busy, 0);

    // Reset at the 4th shift of 0xF0 - 0x0F.
    @(negedge clk);
    op_a  = 8'hF0;
    op_b  = 8'h0F;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 4; n++) @(negedge clk);   // after E3; E4 is the 4th shift
    #1 reset = 1'b1;
    #1;
    chk("midop reset busy", busy, 0);
    chk("midop reset done", done, 0);
    chk("midop reset diff", diff, 0);
    chk("midop reset borrow", borrow, 0);
    done_seen = 0;
    @(negedge clk);
    if (done) done_seen++;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("midop reset no done", done_seen, 0);
    chk("midop reset idle", busy, 0);
    $display("reset mid-operation: aborted");

    run_op("FF-FF", 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing A − B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the inverse-direction counterpart of the combinational full-adder datapath. It serves as the area-minimal arithmetic unit behind a start/done handshake. Operands are captured on start, and the result, borrow and signed-overflow flags are held stable until the next operation completes.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  minuend, captured on accepted start
- op_b  input  WIDTH  subtrahend, captured on accepted start
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle pulse; result valid from this cycle on
- diff  output  WIDTH  A − B modulo 2^WIDTH, registered
- borrow  output  1  unsigned borrow (1 when A < B unsigned)
- overflow  output  1  signed overflow of A − B

## Operation
- Reset (asynchronous, active-high) forces the following, regardless of clk:
  - state = IDLE
  - busy = 0, done = 0
  - diff = 0, borrow = 0, overflow = 0
  - internal shift registers, bit counter and borrow flop cleared
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start = 1 at a clock edge:
  - load op_a and op_b into shift registers
  - store op_a[WIDTH−1] and op_b[WIDTH−1] for the overflow calculation
  - borrow flop = 0, counter = 0
  - go to SHIFT
- SHIFT, each edge, with a0/b0 the current LSBs and br the borrow flop:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - shift operands right by one
  - shift d into the MSB of the working diff register
  - increment counter
  - on the WIDTH-th shift, go to DONE
- Transition to DONE:
  - working diff is copied to the diff output
  - final br_next goes to borrow
  - overflow = (a_msb ≠ b_msb) & (result_msb ≠ a_msb)
- DONE: done = 1 for exactly this cycle; next edge goes to IDLE unconditionally.
- start is ignored in SHIFT and DONE. Operands presented then are not captured and no request is queued.
- op_a and op_b may change freely after the accepting edge.
- diff, borrow and overflow change only on entry to DONE. They hold their values through IDLE and through the next operation's SHIFT phase.
- Arithmetic is modulo 2^WIDTH; the counter is wide enough to hold WIDTH with no wrap.

## Timing
- Edge E0 accepts start. Edges E1..E_WIDTH perform the shifts; the transition into DONE and the output updates happen at E_WIDTH.
- done is high in the cycle after E_WIDTH, i.e. WIDTH cycles after acceptance; outputs are valid in that same cycle.
- State is IDLE after E_(WIDTH+1). The earliest next accept is E_(WIDTH+2), giving a throughput of WIDTH+2 cycles per operation.
- busy rises the cycle after E0 and falls the cycle after E_(WIDTH+1).
- With start held high continuously, operations repeat back-to-back every WIDTH+2 cycles.
- Reset mid-operation aborts with no done pulse; the first accept is possible at the first edge after reset deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
(WIDTH = 8 throughout.)
- Reset applied between clock edges:
  - all outputs go to 0 immediately
  - start held 0 → busy stays 0, done never pulses
- op_a = 0x35, op_b = 0x12, start pulse:
  - done pulses 8 cycles after the accepting edge
  - diff = 0x23, borrow = 0, overflow = 0
  - busy is high for exactly 9 cycles
- op_a = 0x12, op_b = 0x35 → diff = 0xDD, borrow = 1, overflow = 0.
- op_a = 0x80, op_b = 0x01 → diff = 0x7F, borrow = 0, overflow = 1.
- Start an op of 0x35 − 0x12, then pulse start with 0xFF/0x00 during SHIFT and in the DONE cycle:
  - the extra starts are ignored
  - result = 0x23
  - no second done pulse
- Assert reset at the 4th shift of 0xF0 − 0x0F:
  - all outputs go to 0, no done pulse
  - after release, 0xFF − 0xFF → diff = 0x00, borrow = 0, overflow = 0
